regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//  Parametrised successor of the single-read/single-write register file used by the decode stage.
//  - Configurable read-port count, data width and register count.
//  - Integer scoreboard: one pending bit per register.
//  - Optional write-to-read bypass.
//  - Sits between DecodeStage (reads, issue) and the writeback end of ExecuteStage (writes).
//  - Decode uses rd_busy / iss_ready to stall on RAW and WAW hazards.
// PARAMETERS
//  XLEN      32  data width of each register
//  NREGS     32  register count; register 0 hardwired to zero; power of two, >=2
//  NREAD     2   read port count, 1..4
//  BYPASS    1   1: write data forwarded to same-cycle reads; 0: read returns old value
// PORTS
//  clk        in   1                   clock, all state updates on rising edge
//  rst        in   1                   synchronous, active-high reset
//  rd_addr    in   NREAD x AW          read addresses, AW=$clog2(NREGS)
//  rd_data    out  NREAD x XLEN        read data, combinational from rd_addr
//  rd_busy    out  NREAD               register pending and not cleared this cycle
//  wr_en      in   1                   writeback strobe
//  wr_addr    in   AW                  writeback register
//  wr_data    in   XLEN                writeback data
//  iss_valid  in   1                   decode issues instruction with destination iss_rd
//  iss_rd     in   AW                  destination register of issued instruction
//  iss_ready  out  1                   issue accepted this cycle (combinational)
//  pend_cnt   out  $clog2(NREGS+1)     number of pending registers
// BEHAVIOUR
//  Reset (rst=1 at edge):
//  - All registers and pending bits clear; pend_cnt=0.
//  - Combinational outputs then follow from cleared state: rd_data=0, rd_busy=0, iss_ready=1.
//  - Reset overrides wr_en and iss_valid in the same cycle.
//  Read path (zero latency):
//  - rd_addr==0 -> rd_data=0, rd_busy=0.
//  - Otherwise rd_data = regs[rd_addr].
//  - If BYPASS and wr_en and wr_addr==rd_addr!=0 -> rd_data=wr_data.
//  Write path:
//  - wr_en and wr_addr!=0 -> regs[wr_addr] <= wr_data at the edge.
//  - Writes to register 0 are dropped.
//  - Writeback clears pending[wr_addr].
//  Busy (per read port):
//  - rd_busy[i] = pending[rd_addr[i]] & ~(wr_en & wr_addr==rd_addr[i]).
//  - The writeback clear counts in the same cycle in both BYPASS modes.
//  - With BYPASS=0, decode must still not use rd_data from that same cycle.
//  Issue handshake:
//  - iss_ready = (iss_rd==0) | ~pending[iss_rd] | (wr_en & wr_addr==iss_rd).
//  - Transfer when iss_valid & iss_ready.
//  - iss_rd!=0 -> pending[iss_rd] <= 1.
//  - iss_rd==0 -> accepted, no state change.
//  - Not accepted -> no state change; decode holds request (WAW stall).
//  Simultaneous issue and writeback, same register:
//  - Pending stays 1 (new producer wins).
//  - Data still written; pend_cnt unchanged.
//  pend_cnt:
//  - +1 per set, -1 per clear, net 0 when both occur.
//  - Never wraps: a clear of a non-pending register (spurious writeback) leaves it unchanged.
//  - Spurious writeback is legal; data is still written.
//  Invariant: pend_cnt == popcount(pending) at every edge.
//  Reset mid-operation drops all outstanding pending bits; in-flight writebacks arriving afterwards are
//  treated as spurious.
// STRUCTURE
//  - core_pkg holds: XLEN default, reg_addr_t typedef, REG_ZERO constant.
//  - Sub-module reg_scoreboard: pending bits, pend_cnt, iss_ready and rd_busy generation.
//  - Storage and bypass muxes live in regfile_sb.
//  - Read ports built with a generate loop over NREAD.
// TESTING
//  1 Reset -> rd_data=0, rd_busy=0, iss_ready=1, pend_cnt=0.
//  2 Write x5=0xDEADBEEF, read x5 same cycle:
//    - BYPASS=1 -> 0xDEADBEEF that cycle.
//    - BYPASS=0 -> 0 that cycle, 0xDEADBEEF next cycle.
//  3 Write x0=0x1234 and issue rd=0 -> rd_data for x0 stays 0, pend_cnt stays 0.
//  4 Issue rd=7, next cycle read x7 -> rd_busy=1, pend_cnt=1.
//    Then issue rd=7 again -> iss_ready=0.
//    Then wr_en x7 -> rd_busy=0 and iss_ready=1 in that same cycle, pend_cnt 0 after the edge.
//  5 Pending x3, same cycle wr_en x3=0x55 and issue rd=3 -> pending[3] stays 1, pend_cnt=1,
//    regs[3]=0x55.
//  6 Issue rd=1..31 over 31 cycles -> pend_cnt=31.
//    Then spurious writeback to pending-free x0, then rst -> pend_cnt=0, all rd_busy=0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the integer register file and its scoreboard.
//   XLEN_DEF   : default register data width
//   NREGS_DEF  : default register count
//   reg_addr_t : register index type for the default configuration
//   REG_ZERO   : index of the hardwired-zero register
package core_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-register scoreboard: one pending bit per register, pending count,
// issue-ready and per-read-port busy flags.
// Ports:
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_rd_addr  [NREAD*AW]   : read addresses (port g at bits g*AW +: AW)
//   o_rd_busy  [NREAD]      : pending and not being written back this cycle
//   i_wr_en, i_wr_addr      : writeback strobe and register
//   i_iss_valid, i_iss_rd   : issue request and its destination register
//   o_iss_ready             : issue accepted this cycle
//   o_pend_cnt [CW]         : number of pending registers
module reg_scoreboard
    import core_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int NREAD = 2,
    parameter int AW    = $clog2(NREGS),
    parameter int CW    = $clog2(NREGS + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NREAD*AW-1:0]   i_rd_addr,
    output logic [NREAD-1:0]      o_rd_busy,
    input  logic                  i_wr_en,
    input  logic [AW-1:0]         i_wr_addr,
    input  logic                  i_iss_valid,
    input  logic [AW-1:0]         i_iss_rd,
    output logic                  o_iss_ready,
    output logic [CW-1:0]         o_pend_cnt
);

    localparam logic [AW-1:0]    ZERO_ADDR = AW'(REG_ZERO);
    localparam logic [NREGS-1:0] ONE_HOT0  = {{(NREGS-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

    logic [NREGS-1:0] r_pending;
    logic [CW-1:0]    r_pend_cnt;

    logic             w_set;
    logic             w_clr;
    logic [NREGS-1:0] w_set_mask;
    logic [NREGS-1:0] w_clr_mask;
    logic [NREGS-1:0] w_pending_nxt;
    logic [CW-1:0]    w_cnt_nxt;

    // A writeback to the requested destination frees it in the same cycle.
    assign o_iss_ready = (i_iss_rd == ZERO_ADDR) | ~r_pending[i_iss_rd]
                       | (i_wr_en & (i_wr_addr == i_iss_rd));

    assign w_set = i_iss_valid & o_iss_ready & (i_iss_rd != ZERO_ADDR);
    // Only a clear of a register that is actually pending changes the count,
    // so a spurious writeback can never underflow it.
    assign w_clr = i_wr_en & (i_wr_addr != ZERO_ADDR) & r_pending[i_wr_addr];

    assign w_set_mask = w_set ? (ONE_HOT0 << i_iss_rd)  : '0;
    assign w_clr_mask = w_clr ? (ONE_HOT0 << i_wr_addr) : '0;
    // Set applied after clear: a new producer wins over a retiring one.
    assign w_pending_nxt = (r_pending & ~w_clr_mask) | w_set_mask;

    // Pending count next value: +1 per set, -1 per clear, net zero for both.
    always_comb begin
        w_cnt_nxt = r_pend_cnt;
        case ({w_set, w_clr})
            2'b10:   w_cnt_nxt = r_pend_cnt + CNT_ONE;
            2'b01:   w_cnt_nxt = r_pend_cnt - CNT_ONE;
            default: w_cnt_nxt = r_pend_cnt;
        endcase
    end

    // Pending bits and pending count state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pending  <= '0;
            r_pend_cnt <= '0;
        end else begin
            r_pending  <= w_pending_nxt;
            r_pend_cnt <= w_cnt_nxt;
        end
    end

    assign o_pend_cnt = r_pend_cnt;

    for (genvar g = 0; g < NREAD; g++) begin : g_busy
        logic [AW-1:0] w_addr;
        assign w_addr = i_rd_addr[g*AW +: AW];
        // Register 0 is never pending, so it reads as not busy.
        assign o_rd_busy[g] = r_pending[w_addr] & ~(i_wr_en & (i_wr_addr == w_addr));
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port integer register file with pending-register scoreboard.
// Register 0 reads as zero and ignores writes; optional write-to-read bypass.
// Ports:
//   i_clk, i_rst             : clock, synchronous active-high reset
//   i_rd_addr  [NREAD*AW]    : read addresses (port g at bits g*AW +: AW)
//   o_rd_data  [NREAD*XLEN]  : combinational read data (port g at g*XLEN +: XLEN)
//   o_rd_busy  [NREAD]       : source register still pending
//   i_wr_en, i_wr_addr, i_wr_data : writeback port
//   i_iss_valid, i_iss_rd    : issue request and destination register
//   o_iss_ready              : issue accepted this cycle
//   o_pend_cnt [CW]          : number of pending registers
module regfile_sb
    import core_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS),
    localparam int CW    = $clog2(NREGS + 1)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NREAD*AW-1:0]     i_rd_addr,
    output logic [NREAD*XLEN-1:0]   o_rd_data,
    output logic [NREAD-1:0]        o_rd_busy,
    input  logic                    i_wr_en,
    input  logic [AW-1:0]           i_wr_addr,
    input  logic [XLEN-1:0]         i_wr_data,
    input  logic                    i_iss_valid,
    input  logic [AW-1:0]           i_iss_rd,
    output logic                    o_iss_ready,
    output logic [CW-1:0]           o_pend_cnt
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

    logic [XLEN-1:0] r_regs [NREGS];

    // Register storage; writes to register 0 are dropped.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < NREGS; k++) begin
                r_regs[k] <= '0;
            end
        end else if (i_wr_en && (i_wr_addr != ZERO_ADDR)) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    for (genvar g = 0; g < NREAD; g++) begin : g_rd
        logic [AW-1:0] w_addr;
        logic          w_hit;
        assign w_addr = i_rd_addr[g*AW +: AW];
        assign w_hit  = (BYPASS != 0) && i_wr_en && (i_wr_addr == w_addr);
        assign o_rd_data[g*XLEN +: XLEN] = (w_addr == ZERO_ADDR) ? '0
                                         : (w_hit ? i_wr_data : r_regs[w_addr]);
    end

    reg_scoreboard #(
        .NREGS (NREGS),
        .NREAD (NREAD),
        .AW    (AW),
        .CW    (CW)
    ) u_sb (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_rd_addr   (i_rd_addr),
        .o_rd_busy   (o_rd_busy),
        .i_wr_en     (i_wr_en),
        .i_wr_addr   (i_wr_addr),
        .i_iss_valid (i_iss_valid),
        .i_iss_rd    (i_iss_rd),
        .o_iss_ready (o_iss_ready),
        .o_pend_cnt  (o_pend_cnt)
    );

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
    import core_pkg::*;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NREAD = 2;
    localparam int AW    = 5;
    localparam int CW    = 6;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREAD*AW-1:0]   rd_addr;
    logic [NREAD*XLEN-1:0] rd_data, rd_data_nb;
    logic [NREAD-1:0]      rd_busy, rd_busy_nb;
    logic                  wr_en;
    reg_addr_t             wr_addr;
    logic [XLEN-1:0]       wr_data;
    logic                  iss_valid;
    reg_addr_t             iss_rd;
    logic                  iss_ready, iss_ready_nb;
    logic [CW-1:0]         pend_cnt, pend_cnt_nb;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_rd_addr(rd_addr), .o_rd_data(rd_data),
        .o_rd_busy(rd_busy), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_iss_valid(iss_valid), .i_iss_rd(iss_rd), .o_iss_ready(iss_ready),
        .o_pend_cnt(pend_cnt)
    );

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(0)) dut_nb (
        .i_clk(clk), .i_rst(rst), .i_rd_addr(rd_addr), .o_rd_data(rd_data_nb),
        .o_rd_busy(rd_busy_nb), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_iss_valid(iss_valid), .i_iss_rd(iss_rd), .o_iss_ready(iss_ready_nb),
        .o_pend_cnt(pend_cnt_nb)
    );

    // Reference model state
    logic [XLEN-1:0]  m_regs [NREGS];
    logic [NREGS-1:0] m_pend;

    typedef struct packed {
        logic [NREAD*XLEN-1:0] d;
        logic [NREAD*XLEN-1:0] dnb;
        logic [NREAD-1:0]      busy;
        logic                  rdy;
        logic [CW-1:0]         cnt;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        reg_addr_t a;
        e = '0;
        for (int p = 0; p < NREAD; p++) begin
            a = rd_addr[p*AW +: AW];
            if (a != 5'd0) begin
                e.dnb[p*XLEN +: XLEN] = m_regs[a];
                e.d[p*XLEN +: XLEN]   = (wr_en && wr_addr == a) ? wr_data : m_regs[a];
                e.busy[p]             = m_pend[a] && !(wr_en && wr_addr == a);
            end
        end
        e.rdy = (iss_rd == 5'd0) || !m_pend[iss_rd] || (wr_en && wr_addr == iss_rd);
        e.cnt = CW'($countones(m_pend));
        return e;
    endfunction

    // Push the expected outputs for the inputs just driven, then pop and compare.
    task automatic drive_check();
        exp_t e;
        exp_q.push_back(model_out());
        #1;
        e = exp_q.pop_front();
        check("rd_data",     64'(rd_data),      64'(e.d));
        check("rd_data_nb",  64'(rd_data_nb),   64'(e.dnb));
        check("rd_busy",     64'(rd_busy),      64'(e.busy));
        check("rd_busy_nb",  64'(rd_busy_nb),   64'(e.busy));
        check("iss_ready",   64'(iss_ready),    64'(e.rdy));
        check("iss_ready_nb",64'(iss_ready_nb), 64'(e.rdy));
        check("pend_cnt",    64'(pend_cnt),     64'(e.cnt));
        check("pend_cnt_nb", 64'(pend_cnt_nb),  64'(e.cnt));
    endtask

    // Advance one clock and apply the same transfer to the model.
    task automatic tick();
        logic do_set, do_clr, rdy;
        rdy    = (iss_rd == 5'd0) || !m_pend[iss_rd] || (wr_en && wr_addr == iss_rd);
        do_set = iss_valid && rdy && (iss_rd != 5'd0);
        do_clr = wr_en && (wr_addr != 5'd0);
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < NREGS; k++) m_regs[k] = '0;
            m_pend = '0;
        end else begin
            if (do_clr) begin
                m_regs[wr_addr] = wr_data;
                m_pend[wr_addr] = 1'b0;
            end
            if (do_set) m_pend[iss_rd] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        iss_valid = 1'b0; iss_rd = '0;
    endtask

    initial begin
        m_pend = '0;
        idle();
        rst = 1'b1;
        rd_addr = {5'd31, 5'd5};
        @(negedge clk);
        tick();
        rst = 1'b0;

        // 1: reset state
        drive_check();
        check("t1_rd_data", 64'(rd_data), 64'd0);
        check("t1_rd_busy", 64'(rd_busy), 64'd0);
        check("t1_ready",   64'(iss_ready), 64'd1);
        check("t1_cnt",     64'(pend_cnt), 64'd0);

        // 2: write x5 and read it in the same cycle
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rd_addr = {5'd0, 5'd5};
        drive_check();
        check("t2_bypass",    64'(rd_data[31:0]),    64'h0000_0000_DEAD_BEEF);
        check("t2_nobyp_now", 64'(rd_data_nb[31:0]), 64'd0);
        tick();
        idle();
        drive_check();
        check("t2_nobyp_next", 64'(rd_data_nb[31:0]), 64'h0000_0000_DEAD_BEEF);

        // 3: write x0 and issue rd=0
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; iss_valid = 1'b1; iss_rd = 5'd0;
        rd_addr = {5'd0, 5'd0};
        drive_check();
        check("t3_ready", 64'(iss_ready), 64'd1);
        tick();
        idle();
        drive_check();
        check("t3_x0",  64'(rd_data[31:0]), 64'd0);
        check("t3_cnt", 64'(pend_cnt), 64'd0);

        // 4: RAW/WAW on x7
        iss_valid = 1'b1; iss_rd = 5'd7;
        drive_check();
        tick();
        idle();
        rd_addr = {5'd0, 5'd7};
        drive_check();
        check("t4_busy", 64'(rd_busy[0]), 64'd1);
        check("t4_cnt",  64'(pend_cnt), 64'd1);
        iss_valid = 1'b1; iss_rd = 5'd7;
        drive_check();
        check("t4_waw_stall", 64'(iss_ready), 64'd0);
        tick();
        iss_valid = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h77;
        drive_check();
        check("t4_wb_busy",  64'(rd_busy[0]), 64'd0);
        check("t4_wb_ready", 64'(iss_ready), 64'd1);
        tick();
        idle();
        drive_check();
        check("t4_cnt_after", 64'(pend_cnt), 64'd0);

        // 5: simultaneous issue and writeback of pending x3
        iss_valid = 1'b1; iss_rd = 5'd3;
        drive_check();
        tick();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
        drive_check();
        tick();
        idle();
        rd_addr = {5'd0, 5'd3};
        drive_check();
        check("t5_busy", 64'(rd_busy[0]), 64'd1);
        check("t5_cnt",  64'(pend_cnt), 64'd1);
        check("t5_data", 64'(rd_data[31:0]), 64'h55);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h56;
        drive_check();
        tick();
        idle();

        // 6: fill every register, spurious x0 writeback, then reset
        for (int r = 1; r < NREGS; r++) begin
            iss_valid = 1'b1; iss_rd = reg_addr_t'(r); rd_addr = {reg_addr_t'(r), 5'd1};
            drive_check();
            tick();
        end
        idle();
        drive_check();
        check("t6_cnt_full", 64'(pend_cnt), 64'd31);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF;
        drive_check();
        tick();
        check("t6_cnt_x0wb", 64'(pend_cnt), 64'd31);
        rst = 1'b1; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hABCD;
        iss_valid = 1'b1; iss_rd = 5'd9;
        drive_check();
        tick();
        idle();
        rd_addr = {5'd9, 5'd5};
        drive_check();
        check("t6_cnt_rst",  64'(pend_cnt), 64'd0);
        check("t6_busy_rst", 64'(rd_busy), 64'd0);
        check("t6_data_rst", 64'(rd_data), 64'd0);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        drive_check();
        tick();
        idle();
        drive_check();
        check("t6_spurious_cnt",  64'(pend_cnt), 64'd0);
        check("t6_spurious_data", 64'(rd_data[63:32]), 64'h99);

        // Random mixed traffic over a small register window
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 79) == 0);
            wr_en     = $urandom_range(0, 1) == 1;
            wr_addr   = reg_addr_t'($urandom_range(0, 7));
            wr_data   = $urandom;
            iss_valid = $urandom_range(0, 1) == 1;
            iss_rd    = reg_addr_t'($urandom_range(0, 7));
            rd_addr   = {reg_addr_t'($urandom_range(0, 7)), reg_addr_t'($urandom_range(0, 7))};
            drive_check();
            tick();
        end
        idle();
        drive_check();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
